// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings,
// reset-level constants and grant encodings.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    DMEM_ARB_IDLE   = 2'b00,
    DMEM_ARB_ACCESS = 2'b01,
    DMEM_ARB_RESP   = 2'b10
  } dmem_arb_state_e;

  // Reset is active-low: the asserted level is 0.
  localparam logic RST_ENABLE  = 1'b0;
  localparam logic RST_DISABLE = 1'b1;

  // One-hot grant encodings.
  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_PORT0 = 2'b01;
  localparam logic [1:0] GNT_PORT1 = 2'b10;

  // last_gnt reset value: pretend port 1 went last so port 0 wins first.
  localparam logic LAST_GNT_RST = 1'b1;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// rr_pick2: combinational two-way winner select producing a one-hot grant.
// Build option: DMEM_ARB_FIXED_PRIO_EN makes port 0 always win contention;
// otherwise contention goes to the port that was not granted last.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  // Fixed priority: port 0 first, port 1 only when port 0 is quiet.
  always_comb begin
    gnt = GNT_NONE;
    if (req0) begin
      gnt = GNT_PORT0;
    end else if (req1) begin
      gnt = GNT_PORT1;
    end
  end
`else
  // Round-robin: a lone requester wins; on contention the other port than last_gnt wins.
  always_comb begin
    gnt = GNT_NONE;
    if (req0 && req1) begin
      gnt = last_gnt ? GNT_PORT0 : GNT_PORT1;
    end else if (req0) begin
      gnt = GNT_PORT0;
    end else if (req1) begin
      gnt = GNT_PORT1;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer for a single-port data memory.
// Latches one request, drives the memory for one cycle, then acks the owner
// with a one-cycle pulse carrying the read data. Winner selection lives in
// rr_pick2, which honours the DMEM_ARB_FIXED_PRIO_EN build option.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        gnt
);

  dmem_arb_state_e   state_q, state_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              busy_q, busy_d;

  logic              pick_req0;
  logic              pick_req1;
  logic [1:0]        pick_gnt;

  // Requests visible to the picker: none while accessing, and the port
  // being acked is masked in RESP since it has not seen its ack yet.
  always_comb begin
    pick_req0 = 1'b0;
    pick_req1 = 1'b0;
    if (state_q == DMEM_ARB_IDLE) begin
      pick_req0 = req0;
      pick_req1 = req1;
    end else if (state_q == DMEM_ARB_RESP) begin
      pick_req0 = req0 && !gnt_q[0];
      pick_req1 = req1 && !gnt_q[1];
    end
  end

  rr_pick2 u_pick (
    .req0     (pick_req0),
    .req1     (pick_req1),
    .last_gnt (last_gnt_q),
    .gnt      (pick_gnt)
  );

  // Next-state and next-output logic for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    mem_ce_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;

    case (state_q)
      DMEM_ARB_ACCESS: begin
        mem_we_d = 1'b0;
        ack0_d   = gnt_q[0];
        ack1_d   = gnt_q[1];
        if (gnt_q[0]) begin
          rdata0_d = mem_we_q ? '0 : mem_rdata;
        end
        if (gnt_q[1]) begin
          rdata1_d = mem_we_q ? '0 : mem_rdata;
        end
        state_d = DMEM_ARB_RESP;
      end
      DMEM_ARB_IDLE, DMEM_ARB_RESP: begin
        if (pick_gnt != GNT_NONE) begin
          state_d     = DMEM_ARB_ACCESS;
          mem_ce_d    = 1'b1;
          gnt_d       = pick_gnt;
          last_gnt_d  = pick_gnt[1];
          mem_we_d    = pick_gnt[0] ? we0    : we1;
          mem_addr_d  = pick_gnt[0] ? addr0  : addr1;
          mem_wdata_d = pick_gnt[0] ? wdata0 : wdata1;
        end else begin
          state_d = DMEM_ARB_IDLE;
          gnt_d   = GNT_NONE;
        end
      end
      default: begin
        state_d = DMEM_ARB_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase

    busy_d = (state_d != DMEM_ARB_IDLE);
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q     <= DMEM_ARB_IDLE;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      gnt_q       <= GNT_NONE;
      last_gnt_q  <= LAST_GNT_RST;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed transactions push expected acks
// (port, read data, cycle) into a scoreboard; a monitor pops and compares
// on every ack. A small behavioural memory sits behind the arbiter.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;
  logic [1:0]  gnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mem [0:255];
  logic [31:0] hold0, hold1;
  exp_t        mon_e;
  int          mon_port;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata1    (rdata1),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .gnt       (gnt)
  );

  // Clock and free-running cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port memory: combinational read, write on the edge.
  assign mem_rdata = mem_ce ? mem[mem_addr[7:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_ce && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on each ack pop the scoreboard and compare port, data, timing
  // and that the other port's rdata is undisturbed.
  always @(negedge clk) begin
    if (!rst) begin
      hold0 = 32'h0;
      hold1 = 32'h0;
    end else if (ack0 || ack1) begin
      checkOutput("ack_overlap", 32'(ack0 & ack1), 32'h0);
      mon_port = ack1 ? 1 : 0;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack: got ack on port %0d expected none", mon_port);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("ack_port", 32'(mon_port), 32'(mon_e.port));
        checkOutput("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.port == 0) begin
          checkOutput("rdata0", rdata0, mon_e.rdata);
          checkOutput("rdata1_hold", rdata1, hold1);
          hold0 = mon_e.rdata;
        end else begin
          checkOutput("rdata1", rdata1, mon_e.rdata);
          checkOutput("rdata0_hold", rdata0, hold0);
          hold1 = mon_e.rdata;
        end
      end
    end
  end

  task automatic doReset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One single-port transaction started from IDLE, #1 after a clock edge.
  task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rexp);
    int  c;
    bit  seen;
    exp_t e;
    c = cyc;
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end
    e.port = port; e.rdata = rexp; e.cyc = c + 2;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    checkOutput("access_ce", 32'(mem_ce), 32'h1);
    checkOutput("access_we", 32'(mem_we), 32'(we));
    checkOutput("access_addr", mem_addr, addr);
    if (we) checkOutput("access_wdata", mem_wdata, wdata);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: port %0d got no ack expected one", port);
    end
    @(posedge clk);
    #1;
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    int   c;
    exp_t e;
    rst = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;

    // Reset, then idle with no requests.
    doReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_ce", 32'(mem_ce), 32'h0);
      checkOutput("idle_busy", 32'(busy), 32'h0);
      checkOutput("idle_gnt", 32'(gnt), 32'h0);
      checkOutput("idle_ack", 32'({ack0, ack1}), 32'h0);
      checkOutput("idle_rdata0", rdata0, 32'h0);
      checkOutput("idle_rdata1", rdata1, 32'h0);
      checkOutput("idle_addr", mem_addr, 32'h0);
    end
    @(posedge clk); #1;

    // Preload, then port 0 write/read round trip.
    applyStimulus(0, 1'b1, 32'h00, 32'h1111_1111, 32'h0);
    applyStimulus(1, 1'b1, 32'h04, 32'h2222_2222, 32'h0);
    applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);

    // Contention after reset: order 0,1,0,1, acks 2 cycles apart.
    doReset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h04;
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      e.port  = k % 2;
      e.rdata = (k % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
      e.cyc   = c + 2 + 2 * k;
      sb.push_back(e);
    end
    repeat (7) @(posedge clk);
    #1 req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 req1 = 1'b0;
    @(negedge clk);
    checkOutput("contend_busy_end", 32'(busy), 32'h0);
    @(posedge clk); #1;

    // Port 1 write whose request drops during ACCESS still completes once.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hCAFE_F00D;
    e.port = 1; e.rdata = 32'h0; e.cyc = cyc + 2;
    sb.push_back(e);
    @(posedge clk);
    #1 req1 = 1'b0;
    @(negedge clk);
    checkOutput("abandon_ce", 32'(mem_ce), 32'h1);
    checkOutput("abandon_we", 32'(mem_we), 32'h1);
    checkOutput("abandon_addr", mem_addr, 32'h20);
    repeat (4) @(negedge clk);
    checkOutput("abandon_busy", 32'(busy), 32'h0);
    checkOutput("abandon_mem", mem[8'h20], 32'hCAFE_F00D);
    @(posedge clk); #1;

    // Reset during ACCESS aborts with no ack; a fresh request then works.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h00;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_ce_before", 32'(mem_ce), 32'h1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_ce", 32'(mem_ce), 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_gnt", 32'(gnt), 32'h0);
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 32'h04, 32'h0, 32'h2222_2222);

    // Drain: every expected ack must have been seen.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending acks expected 0", sb.size());
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory (ce/we/addr/dataIn/dataOut interface).
- Port 0 serves the CPU MEM stage; port 1 serves a second master (boot loader, debug or DMA).
- Latches one request at a time, drives the memory for exactly one cycle, then returns read data with a one-cycle ack pulse.
- Sits between the masters and the data memory inside the SoC top.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- req0  in  1  port 0 request; held with its qualifiers until ack0.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 completion pulse.
- rdata0  out  DATA_W  port 0 read data, valid while ack0 = 1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_ce  out  1  memory chip enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; combinational while mem_ce = 1.
- busy  out  1  high whenever the state is not IDLE.
- gnt  out  2  one-hot owner of the current transaction; 00 when idle.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - All outputs 0: mem_ce, mem_we, mem_addr, mem_wdata, ack0/1, rdata0/1, gnt, busy.
  - last_gnt = 1, so port 0 wins the first contention.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select a winner.
  - Latch the winner's we/addr/wdata into internal registers and set gnt.
  - Next state = ACCESS.
- ACCESS (exactly one cycle):
  - mem_ce = 1, with mem_we/mem_addr/mem_wdata from the latched values.
  - The memory performs a write on this clock edge when mem_we = 1.
  - On a read, mem_rdata is captured at the end of the cycle into the winner's rdata register.
  - Next state = RESP.
- RESP:
  - ack of the owning port = 1 for one cycle; mem_ce = 0.
  - rdata of the owning port holds the captured value; it is 0 after a write.
  - The other port's rdata holds its previous value.
  - In this same cycle, if a request is pending from a port other than the one being acked, arbitrate and go directly to ACCESS (back-to-back).
  - Otherwise go to IDLE; gnt = 00.
  - The acked port's req is ignored during RESP, because its owner has not yet seen the ack.
- Latency and throughput:
  - A req sampled high in IDLE at edge N gives ACCESS in cycle N+1 and ack in cycle N+2.
  - Sustained alternating traffic completes one transaction every 2 cycles.
  - A single requester alone completes one transaction every 3 cycles.
- Arbitration:
  - Only one requesting: that port wins.
  - Both requesting: the port ≠ last_gnt wins (round-robin).
  - last_gnt updates on every grant.
- Request abandonment:
  - A req dropped before it is latched is never served.
  - Once latched, the transaction completes and ack pulses even if req has dropped.
- ack0 and ack1 are never high together. mem_ce is never high in two consecutive cycles for the same grant.
- Reset mid-ACCESS aborts asynchronously. A write whose edge coincides with reset assertion is not guaranteed. No ack is issued for the aborted transaction.
- Address and data pass through unmodified; no alignment or width conversion.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins contention; last_gnt is not used; port 1 can starve.
- Undefined (default): round-robin as described above.

Decomposition:
- Shared def package:
  - State encodings DMEM_ARB_IDLE = 2'b00, DMEM_ARB_ACCESS = 2'b01, DMEM_ARB_RESP = 2'b10.
  - Existing RST_ENABLE/RST_DISABLE constants redefined consistently with active-low reset.
- Sub-module rr_pick2: combinational winner select from (req0, req1, last_gnt), producing a one-hot grant.
  - Contains the DMEM_ARB_FIXED_PRIO_EN switch.
  - Reused by later bus arbiters.

Test Plan:
- Reset held 3 cycles, then released with no requests -> all outputs 0, busy = 0, mem_ce never asserted.
- Port 0 write addr = 0x10, data = 0xDEADBEEF, then port 0 read addr = 0x10:
  - Write: mem_ce = 1, mem_we = 1 exactly one cycle after req is sampled.
  - ack0 pulses 2 cycles after req is sampled.
  - Read: rdata0 = 0xDEADBEEF during ack0.
- req0 and req1 both held for 4 transactions (reads of 0x00 and 0x04):
  - Grant order is 0, 1, 0, 1.
  - acks are spaced 2 cycles apart; ack0 and ack1 are never simultaneous.
- Same as above with DMEM_ARB_FIXED_PRIO_EN defined:
  - Grant order is 0, 0, 0, 0 while req0 is held.
  - Port 1 is served only after req0 drops.
- req1 raised for one cycle, then dropped in the ACCESS cycle:
  - The write to 0x20 still happens.
  - ack1 pulses once; the FSM returns to IDLE.
- rst asserted during ACCESS:
  - mem_ce drops immediately (asynchronously); no ack is issued.
  - After release, a new port 0 request is granted normally with a 2-cycle ack latency.
